// File: rtl/rr_mux_arbiter_4x32_pkg.sv
// rtl/rr_mux_arbiter_4x32_pkg.sv - shared requester count, selector encodings and helpers
package rr_mux_arbiter_4x32_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_REQ0 = 2'b00;
  localparam sel_t SEL_REQ1 = 2'b01;
  localparam sel_t SEL_REQ2 = 2'b10;
  localparam sel_t SEL_REQ3 = 2'b11;

  function automatic logic [NUM_REQ-1:0] sel_to_onehot(input sel_t sel);
    return NUM_REQ'(1) << sel;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_4x32_grant.sv
// rtl/rr_mux_arbiter_4x32_grant.sv - rr_grant_4: combinational rotating-priority encoder
module rr_grant_4
  import rr_mux_arbiter_4x32_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  sel_t               last_grant_i,
  input  logic               enable_i,
  output logic [NUM_REQ-1:0] grant_oh_o,
  output sel_t               grant_idx_o
);

  sel_t cand;
  logic found;

  // Scan last+1 .. last+4; the 2-bit add wraps so last+4 lands back on last.
  always_comb begin
    grant_oh_o  = '0;
    grant_idx_o = last_grant_i;
    found       = 1'b0;
    cand        = last_grant_i;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last_grant_i + sel_t'(k);
      if (enable_i && !found && req_valid_i[cand]) begin
        found       = 1'b1;
        grant_idx_o = cand;
        grant_oh_o  = sel_to_onehot(cand);
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter_4x32_mux.sv
// rtl/rr_mux_arbiter_4x32_mux.sv - 4:1 word mux addressed by the shared selector encoding
module mux4_32
  import rr_mux_arbiter_4x32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  sel_t             sel_i,
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  input  logic [WIDTH-1:0] d2_i,
  input  logic [WIDTH-1:0] d3_i,
  output logic [WIDTH-1:0] y_o
);

  // Every selector value is enumerated, so there is no fall-through path.
  always_comb begin
    unique case (sel_i)
      SEL_REQ0: y_o = d0_i;
      SEL_REQ1: y_o = d1_i;
      SEL_REQ2: y_o = d2_i;
      SEL_REQ3: y_o = d3_i;
    endcase
  end

endmodule

// File: rtl/rr_mux_arbiter_4x32.sv
// rtl/rr_mux_arbiter_4x32.sv - round-robin 4:1 arbiter with registered output stage
// Optional burst lock (req_lock port) enabled by defining ARB_LOCK_EN.
module rr_mux_arbiter_4x32
  import rr_mux_arbiter_4x32_pkg::*;
#(
  parameter int   DATA_WIDTH = 32,
  parameter sel_t RESET_LAST = SEL_REQ3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic [DATA_WIDTH-1:0] req2_data,
  input  logic [DATA_WIDTH-1:0] req3_data,
`ifdef ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]    req_lock,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [SEL_W-1:0]      out_sel
);

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  sel_t                  out_sel_q, out_sel_d;
  sel_t                  last_grant_q, last_grant_d;

  logic                  slot_free;
  logic [NUM_REQ-1:0]    rr_oh;
  sel_t                  rr_idx;
  logic [NUM_REQ-1:0]    grant_oh;
  sel_t                  grant_idx;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] mux_data;

  // The slot counts as free while the consumer drains it, giving one word per cycle.
  assign slot_free = !out_valid_q || out_ready;

  rr_grant_4 u_grant (
    .req_valid_i  (req_valid),
    .last_grant_i (last_grant_q),
    .enable_i     (slot_free),
    .grant_oh_o   (rr_oh),
    .grant_idx_o  (rr_idx)
  );

`ifdef ARB_LOCK_EN
  logic lock_q, lock_d;
  logic lock_hit;

  // A locked requester that is still valid jumps ahead of the rotation.
  assign lock_hit  = lock_q && req_valid[last_grant_q] && slot_free;
  assign grant_oh  = lock_hit ? sel_to_onehot(last_grant_q) : rr_oh;
  assign grant_idx = lock_hit ? last_grant_q : rr_idx;

  always_comb begin
    lock_d = lock_q;
    if (xfer) begin
      lock_d = req_lock[grant_idx];
    end else if (slot_free && !req_valid[last_grant_q]) begin
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end
`else
  assign grant_oh  = rr_oh;
  assign grant_idx = rr_idx;
`endif

  assign xfer      = |grant_oh;
  assign req_ready = grant_oh;

  mux4_32 #(.WIDTH(DATA_WIDTH)) u_mux (
    .sel_i (grant_idx),
    .d0_i  (req0_data),
    .d1_i  (req1_data),
    .d2_i  (req2_data),
    .d3_i  (req3_data),
    .y_o   (mux_data)
  );

  // Data and selector only move on a transfer; a plain drain just clears valid.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    last_grant_d = last_grant_q;
    if (xfer) begin
      out_valid_d  = 1'b1;
      out_data_d   = mux_data;
      out_sel_d    = grant_idx;
      last_grant_d = grant_idx;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sel_q    <= SEL_REQ0;
      last_grant_q <= RESET_LAST;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arbiter_4x32.sv
// tb/tb_rr_mux_arbiter_4x32.sv - self-checking bench for rr_mux_arbiter_4x32
module tb_rr_mux_arbiter_4x32;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] rdat [4];
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_sel;
`ifdef ARB_LOCK_EN
  logic [3:0]  req_lock = 4'b0000;
`endif

  int checks = 0;
  int errors = 0;

  bit          m_valid;
  logic [31:0] m_data;
  int          m_sel;
  int          m_last;

  rr_mux_arbiter_4x32 dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req0_data (rdat[0]),
    .req1_data (rdat[1]),
    .req2_data (rdat[2]),
    .req3_data (rdat[3]),
`ifdef ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Rotating priority: first valid index after the last winner, modulo 4.
  function automatic int pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (v[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic int model_grant();
    if (m_valid && !out_ready) return -1;
    return pick(req_valid, m_last);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 32'h0;
    m_sel   = 0;
    m_last  = 3;
  endtask

  task automatic compare_model();
    int g;
    logic [3:0] er;
    g  = model_grant();
    er = (g >= 0) ? 4'(1 << g) : 4'b0000;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", out_data, m_data);
    chk("out_sel", 32'(out_sel), 32'(m_sel));
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle(output int g);
    #1;
    compare_model();
    g = model_grant();
    @(posedge clock);
    if (g >= 0) begin
      m_valid = 1'b1;
      m_data  = rdat[g];
      m_sel   = g;
      m_last  = g;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 4'b0000;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  int          g;
  logic [31:0] saved;
  logic [3:0]  ready_tab [5];
  int          sel_tab [5];
  bit          pend [4];
  int          wc [4];

  initial begin
    for (int i = 0; i < 4; i++) rdat[i] = 32'h0;
    do_reset();

    // Reset state and first acceptance latency.
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_sel", 32'(out_sel), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    req_valid = 4'b0001;
    rdat[0]   = 32'hDEAD_BEEF;
    out_ready = 1'b1;
    #1 chk("t1_ready", 32'(req_ready), 32'h1);
    cycle(g);
    req_valid = 4'b0000;
    #1;
    chk("t1_out_valid", 32'(out_valid), 32'h1);
    chk("t1_out_data", out_data, 32'hDEAD_BEEF);
    chk("t1_out_sel", 32'(out_sel), 32'h0);
    cycle(g);

    // All four valid: one grant per cycle in rotation from requester 0.
    do_reset();
    ready_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    sel_tab   = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 4; i++) rdat[i] = 32'h1000_0000 + 32'(i);
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 chk("t2_ready", 32'(req_ready), 32'(ready_tab[k]));
      cycle(g);
      chk("t2_out_sel", 32'(out_sel), 32'(sel_tab[k]));
      chk("t2_out_data", out_data, 32'h1000_0000 + 32'(sel_tab[k]));
    end

    // Backpressure holds everything; release accepts requester 1 then 2.
    out_ready = 1'b0;
    req_valid = 4'b0110;
    saved     = 32'h1000_0000;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_ready_bp", 32'(req_ready), 32'h0);
      chk("t3_data_bp", out_data, saved);
      cycle(g);
    end
    out_ready = 1'b1;
    #1 chk("t3_ready_rel", 32'(req_ready), 32'h2);
    cycle(g);
    #1;
    chk("t3_sel_1", 32'(out_sel), 32'h1);
    chk("t3_ready_next", 32'(req_ready), 32'h4);
    cycle(g);

    // Wrap-around from last_grant=2 with requesters 0 and 2 valid.
    req_valid = 4'b0101;
    #1 chk("t4_wrap0", 32'(req_ready), 32'h1);
    cycle(g);
    #1 chk("t4_then2", 32'(req_ready), 32'h4);
    cycle(g);
    #1 chk("t4_again0", 32'(req_ready), 32'h1);
    cycle(g);

    // Asynchronous reset while the output register is full.
    req_valid = 4'b0000;
    out_ready = 1'b0;
    #1 chk("t5_full", 32'(out_valid), 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("t5_async_valid", 32'(out_valid), 32'h0);
    chk("t5_async_data", out_data, 32'h0);
    chk("t5_async_sel", 32'(out_sel), 32'h0);
    model_reset();
    @(negedge clock);
    reset     = 1'b0;
    req_valid = 4'b1100;
    out_ready = 1'b1;
    #1 chk("t5_first_grant", 32'(req_ready), 32'h4);
    cycle(g);

    // Randomized traffic obeying the hold-until-ready rule, plus fairness tracking.
    for (int i = 0; i < 4; i++) begin
      pend[i] = 1'b0;
      wc[i]   = 0;
    end
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom % 3 == 0)) begin
          pend[i] = 1'b1;
          rdat[i] = $urandom;
        end else if (pend[i] && ($urandom % 20 == 0)) begin
          pend[i] = 1'b0;
        end
        req_valid[i] = pend[i];
      end
      out_ready = ($urandom % 4 != 0);
      cycle(g);
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i]) wc[i] = 0;
        else if (g >= 0) begin
          if (i == g) wc[i] = 0;
          else wc[i]++;
        end
        if (g >= 0) chk("fairness", 32'(wc[i] <= 3), 32'h1);
      end
      if (g >= 0) pend[g] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
